mem_responder: RTL and testbench

- Memory-side responder for the CPU datapath's MAR/MDR memory interface.
- Accepts single-word read/write requests, inserts a fixed number of wait states, and commits the access.
- Pulses mem_ready on completion and returns read data that the datapath muxes into MDR.
- Sits between the datapath and an internal synchronous single-port RAM; the datapath/control unit is the initiator.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/sync_ram.sv | 26 ++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the MAR/MDR memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/sync_ram.sv
// Single-port RAM: synchronous write, registered read (read-before-write on the same address).
module sync_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] dout_q;

    // NOTE: the array has no reset; clearing it would turn the RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one read/write request, waits WAIT_CYCLES, commits the access, pulses mem_ready.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       mar_in,
    input  logic [31:0]       mdr_in,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] mdata_out,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    op_e               op_q, op_d;
    logic              oob_q, oob_d;
    logic              conflict_q, conflict_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;

    logic              live_oob;
    logic              access;
    op_e               acc_op;
    logic              acc_oob;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              read_done;

    assign live_oob = |mar_in[31:ADDR_W];

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        oob_d      = oob_q;
        conflict_d = 1'b0;
        mdata_d    = mdata_q;
        access     = 1'b0;
        acc_op     = op_q;
        acc_oob    = oob_q;
        ram_addr   = addr_q;
        ram_din    = wdata_q;

        case (state_q)
            IDLE: begin
                ram_addr = mar_in[ADDR_W-1:0];
                ram_din  = mdr_in[DATA_W-1:0];
                if (read && write) begin
                    conflict_d = 1'b1;
                end else if (read || write) begin
                    addr_d  = mar_in[ADDR_W-1:0];
                    wdata_d = mdr_in[DATA_W-1:0];
                    op_d    = write ? OP_WRITE : OP_READ;
                    oob_d   = live_oob;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access commits on the sampling edge itself.
                        state_d = DONE;
                        access  = 1'b1;
                        acc_op  = op_d;
                        acc_oob = live_oob;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    access  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (read_done) begin
                    mdata_d = ram_dout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write caught by reset on its commit edge is dropped.
    assign ram_we = access && (acc_op == OP_WRITE) && !acc_oob && clr;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_READ;
            oob_q      <= 1'b0;
            conflict_q <= 1'b0;
            mdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            oob_q      <= oob_d;
            conflict_q <= conflict_d;
            mdata_q    <= mdata_d;
        end
    end

    sync_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (ram_din),
        .dout(ram_dout)
    );

    // RAM output is registered on the access edge, so it is shown directly during DONE, then held.
    assign read_done = (state_q == DONE) && (op_q == OP_READ) && !oob_q;
    assign mdata_out = read_done ? ram_dout : mdata_q;
    assign mem_ready = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign err       = conflict_q || ((state_q == DONE) && oob_q);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a transaction-level memory model.
module tb_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] mar_in, mdr_in;
    logic        read, write;
    logic [31:0] mdata_out;
    logic        mem_ready, busy, err;

    logic [31:0] mar0, mdr0;
    logic        read0, write0;
    logic [31:0] mdata0;
    logic        rdy0, busy0, err0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [512];
    logic [31:0] exp_mdata;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .clr(clr), .mar_in(mar_in), .mdr_in(mdr_in),
        .read(read), .write(write), .mdata_out(mdata_out),
        .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .clr(clr), .mar_in(mar0), .mdr_in(mdr0),
        .read(read0), .write(write0), .mdata_out(mdata0),
        .mem_ready(rdy0), .busy(busy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request held for a single cycle; inputs are scrambled while it is in flight.
    task automatic req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        bit both = rd && wr;
        bit oob  = (addr[31:9] != 0);
        @(negedge clk);
        read = rd; write = wr; mar_in = addr; mdr_in = data;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        mar_in = $urandom_range(0, 15); mdr_in = $urandom;
        if (both) begin
            check("conflict_flags", {busy, mem_ready, err}, 3'b001);
            @(negedge clk);
            check("conflict_clear", {busy, mem_ready, err}, 3'b000);
            check("conflict_mdata", mdata_out, exp_mdata);
            return;
        end
        for (int i = 1; i <= W; i++) begin
            check("wait_flags", {busy, mem_ready, err}, 3'b100);
            @(negedge clk);
        end
        if (!oob && rd) exp_mdata = model_mem[addr[8:0]];
        if (!oob && wr) model_mem[addr[8:0]] = data;
        check("done_flags", {busy, mem_ready, err}, {1'b1, 1'b1, oob});
        check("done_mdata", mdata_out, exp_mdata);
        @(negedge clk);
        check("idle_flags", {busy, mem_ready, err}, 3'b000);
        check("idle_mdata", mdata_out, exp_mdata);
    endtask

    initial begin
        logic [31:0] v0;
        int op;
        logic [31:0] a;

        clr = 1'b0;
        read = 1'b0; write = 1'b0; mar_in = '0; mdr_in = '0;
        read0 = 1'b0; write0 = 1'b0; mar0 = '0; mdr0 = '0;
        exp_mdata = '0;
        repeat (3) @(negedge clk);
        check("reset_flags", {busy, mem_ready, err}, 3'b000);
        check("reset_mdata", mdata_out, 32'h0);
        clr = 1'b1;

        for (int i = 0; i < 16; i++) req(1'b0, 1'b1, i, $urandom);

        req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        req(1'b1, 1'b0, 32'd5, 32'h0);
        check("read_deadbeef", mdata_out, 32'hDEADBEEF);
        req(1'b0, 1'b1, 32'd6, 32'h11112222);
        check("write_keeps_mdata", mdata_out, 32'hDEADBEEF);
        req(1'b1, 1'b1, 32'd5, 32'h12345678);
        req(1'b1, 1'b0, 32'd5, 32'h0);
        check("conflict_no_write", mdata_out, 32'hDEADBEEF);
        req(1'b1, 1'b0, 32'd6, 32'h0);
        req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        req(1'b0, 1'b1, 32'h8000_0205, 32'hCAFEF00D);
        req(1'b1, 1'b0, 32'd5, 32'h0);

        // Reset in the middle of a write: outputs clear and the write never lands.
        @(negedge clk);
        write = 1'b1; mar_in = 32'd7; mdr_in = 32'hA5A5A5A5;
        @(negedge clk);
        write = 1'b0; clr = 1'b0;
        @(negedge clk);
        check("midreset_flags", {busy, mem_ready, err}, 3'b000);
        check("midreset_mdata", mdata_out, 32'h0);
        exp_mdata = '0;
        clr = 1'b1;
        req(1'b1, 1'b0, 32'd7, 32'h0);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 4);
            a  = $urandom_range(0, 15);
            if (op >= 3) a = a | (32'($urandom_range(1, 32'h7F_FFFF)) << 9);
            case (op)
                0, 3:    req(1'b1, 1'b0, a, $urandom);
                1, 4:    req(1'b0, 1'b1, a, $urandom);
                default: req(1'b1, 1'b1, a, $urandom);
            endcase
        end

        // Zero-wait instance: single write, then a read held for four edges.
        v0 = $urandom;
        @(negedge clk);
        write0 = 1'b1; mar0 = 32'd3; mdr0 = v0;
        @(negedge clk);
        check("w0_write_done", {busy0, rdy0, err0}, 3'b110);
        write0 = 1'b0;
        @(negedge clk);
        check("w0_idle", {busy0, rdy0, err0}, 3'b000);
        read0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w0_held_ready", rdy0, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("w0_held_mdata", mdata0, v0);
        end
        read0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
